command_encoder: RTL
====================

Name: command_encoder

Overview:
- Serialises pixel-write and palette-write requests into the host-link byte protocol and drives a UART transmitter.
- Byte stream format:
  - Set-pixel: 0x01, X[15:8], X[7:0], Y[15:8], Y[7:0], colour.
  - Set-palette: 0x02, index, R, G, B.
- Used as the link source when one board drives another display board, and as the stimulus generator for the display-side command decoder in loopback.

Parameters:
- FB_WIDTH, 320, pixel X range limit. Requests with X >= FB_WIDTH are dropped.
- FB_HEIGHT, 200, pixel Y range limit. Requests with Y >= FB_HEIGHT are dropped.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_req_valid  in  1  pixel write request
- pixel_req_ready  out  1  pixel request accepted when valid&&ready
- pixel_x  in  9  X coordinate
- pixel_y  in  8  Y coordinate
- pixel_color  in  8  palette index to write
- pal_req_valid  in  1  palette write request
- pal_req_ready  out  1  palette request accepted when valid&&ready
- pal_index  in  8  palette entry
- pal_r  in  4  red component
- pal_g  in  4  green component
- pal_b  in  4  blue component
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  transmitter accepts byte when tx_valid&&tx_ready
- busy  out  1  frame in progress (state != IDLE)
- req_dropped  out  1  one-cycle pulse when an out-of-range pixel request is discarded

Behaviour:
- Reset values: all outputs 0 except pixel_req_ready=1 and pal_req_ready=1. State=IDLE, byte_idx=0. Latched fields are cleared.
- Both ready outputs are registered and equal (state==IDLE). They deassert in the cycle after acceptance.
- IDLE, pixel_req_valid=1, in range:
  - Latch {x zero-extended to 16 bits, y zero-extended to 16 bits, colour}.
  - Go to SEND_PIXEL with byte_idx=0.
- IDLE, pixel_req_valid=1, out of range (x >= FB_WIDTH or y >= FB_HEIGHT):
  - Request is accepted (ready was high). No bytes are emitted.
  - req_dropped pulses 1 on the next cycle. State stays IDLE.
- IDLE, pal_req_valid=1, pixel_req_valid=0:
  - Latch the request and go to SEND_PALETTE with byte_idx=0.
  - Components are expanded to 8 bits as {c,c} (e.g. 0xA becomes 0xAA), so the decoder's upper-nibble truncation recovers c exactly.
- Simultaneous pixel_req_valid and pal_req_valid in IDLE: pixel wins. The palette request is not accepted; its ready stays high but the handshake is not consumed, because acceptance for palette is pal_req_valid && ready && !pixel_req_valid.
  - Correction for unambiguity: pal_req_ready = (state==IDLE) && !pixel_req_valid. This path is combinational on pixel_req_valid only.
- SEND_PIXEL / SEND_PALETTE:
  - tx_valid=1 and tx_data = byte[byte_idx], registered.
  - First byte appears the cycle after acceptance (latency 1).
  - On each tx_valid&&tx_ready, byte_idx increments and the next byte is presented the following cycle. tx_valid remains 1 back-to-back, so throughput is 1 byte per cycle if tx_ready stays high.
  - tx_data and tx_valid must not change while tx_valid=1 and tx_ready=0.
- Last byte (idx 5 pixel, idx 4 palette) accepted: next cycle tx_valid=0, state=IDLE, readies=1.
- Minimum request-to-request period, with tx_ready held high: 7 cycles pixel, 6 cycles palette.
- busy=1 from the cycle after acceptance until the cycle the state returns to IDLE.
- Requests arriving while busy are ignored (ready=0). Inputs are sampled only at acceptance; later input changes do not affect the frame in flight.
- Reset mid-frame: the next cycle has tx_valid=0 and state IDLE. The partial frame is abandoned. Resynchronising the link is the responsibility of the system, which resets both ends together.

Test Plan:
- Pixel (x=0x13F, y=0xC7, colour=0x5A), tx_ready=1 -> bytes 01,01,3F,00,C7,5A on 6 consecutive cycles starting 1 cycle after accept; ready high again on cycle 7.
- Palette (index=0x10, r=0xF, g=0x0, b=0xA) with tx_ready toggling 1/0 every cycle -> bytes 02,10,FF,00,AA; each byte held stable while tx_ready=0; no byte duplicated or skipped.
- Pixel x=320, y=0 and x=0, y=200 -> no tx_valid; req_dropped pulses once per request; x=319, y=199 is sent normally.
- Pixel and palette valid in the same IDLE cycle -> pixel frame sent first; palette held valid is accepted in the first IDLE cycle after and sent next.
- Reset asserted after 3 pixel bytes -> tx_valid=0 next cycle, readies=1, busy=0; a subsequent palette request produces a clean 5-byte frame.
- Loopback into the display command decoder, 50 random pixel and palette requests -> decoder framebuffer and palette writes match the requests exactly; out-of-range pixels produce no writes.

Source files
------------

// File: rtl/command_encoder.sv
// +----------------------------------------------------------------------------+
// | command_encoder: serialises pixel/palette writes into host-link bytes.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module command_encoder #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_req_valid,
  output logic       pixel_req_ready,
  input  logic [8:0] pixel_x,
  input  logic [7:0] pixel_y,
  input  logic [7:0] pixel_color,
  input  logic       pal_req_valid,
  output logic       pal_req_ready,
  input  logic [7:0] pal_index,
  input  logic [3:0] pal_r,
  input  logic [3:0] pal_g,
  input  logic [3:0] pal_b,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       req_dropped
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PIXEL   = 2'd1;
  localparam logic [1:0] ST_PALETTE = 2'd2;

  localparam logic [2:0] PIXEL_LAST = 3'd5;
  localparam logic [2:0] PAL_LAST   = 3'd4;

  logic [1:0]  state_q, state_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [7:0]  color_q, color_d;
  logic [7:0]  pal_index_q, pal_index_d;
  logic [7:0]  pal_r_q, pal_r_d;
  logic [7:0]  pal_g_q, pal_g_d;
  logic [7:0]  pal_b_q, pal_b_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        ready_q, ready_d;
  logic        dropped_q, dropped_d;

  logic [15:0] x_ext;
  logic [15:0] y_ext;
  logic        in_range;
  logic        tx_fire;

  function automatic logic [7:0] pixel_byte(input logic [2:0] idx, input logic [15:0] x,
                                            input logic [15:0] y, input logic [7:0] c);
    case (idx)
      3'd0:    return 8'h01;
      3'd1:    return x[15:8];
      3'd2:    return x[7:0];
      3'd3:    return y[15:8];
      3'd4:    return y[7:0];
      default: return c;
    endcase
  endfunction

  function automatic logic [7:0] pal_byte(input logic [2:0] idx, input logic [7:0] index,
                                          input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
    case (idx)
      3'd0:    return 8'h02;
      3'd1:    return index;
      3'd2:    return r;
      3'd3:    return g;
      default: return b;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_idx_q  <= 3'd0;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      color_q     <= 8'd0;
      pal_index_q <= 8'd0;
      pal_r_q     <= 8'd0;
      pal_g_q     <= 8'd0;
      pal_b_q     <= 8'd0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      ready_q     <= 1'b1;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      color_q     <= color_d;
      pal_index_q <= pal_index_d;
      pal_r_q     <= pal_r_d;
      pal_g_q     <= pal_g_d;
      pal_b_q     <= pal_b_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      ready_q     <= ready_d;
      dropped_q   <= dropped_d;
    end
  end

  always_comb begin
    x_ext    = {7'd0, pixel_x};
    y_ext    = {8'd0, pixel_y};
    in_range = (x_ext < 16'(FB_WIDTH)) && (y_ext < 16'(FB_HEIGHT));
    tx_fire  = tx_valid_q && tx_ready;

    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    x_d         = x_q;
    y_d         = y_q;
    color_d     = color_q;
    pal_index_d = pal_index_q;
    pal_r_d     = pal_r_q;
    pal_g_d     = pal_g_q;
    pal_b_d     = pal_b_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    ready_d     = ready_q;
    dropped_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Pixel has priority; an out-of-range pixel is consumed without output.
        if (pixel_req_valid) begin
          if (in_range) begin
            x_d        = x_ext;
            y_d        = y_ext;
            color_d    = pixel_color;
            state_d    = ST_PIXEL;
            byte_idx_d = 3'd0;
            tx_data_d  = pixel_byte(3'd0, x_ext, y_ext, pixel_color);
            tx_valid_d = 1'b1;
            ready_d    = 1'b0;
          end else begin
            dropped_d = 1'b1;
          end
        end else if (pal_req_valid) begin
          pal_index_d = pal_index;
          pal_r_d     = {pal_r, pal_r};
          pal_g_d     = {pal_g, pal_g};
          pal_b_d     = {pal_b, pal_b};
          state_d     = ST_PALETTE;
          byte_idx_d  = 3'd0;
          tx_data_d   = 8'h02;
          tx_valid_d  = 1'b1;
          ready_d     = 1'b0;
        end
      end
      ST_PIXEL: begin
        if (tx_fire) begin
          if (byte_idx_q == PIXEL_LAST) begin
            state_d    = ST_IDLE;
            byte_idx_d = 3'd0;
            tx_data_d  = 8'd0;
            tx_valid_d = 1'b0;
            ready_d    = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            tx_data_d  = pixel_byte(byte_idx_q + 3'd1, x_q, y_q, color_q);
          end
        end
      end
      ST_PALETTE: begin
        if (tx_fire) begin
          if (byte_idx_q == PAL_LAST) begin
            state_d    = ST_IDLE;
            byte_idx_d = 3'd0;
            tx_data_d  = 8'd0;
            tx_valid_d = 1'b0;
            ready_d    = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            tx_data_d  = pal_byte(byte_idx_q + 3'd1, pal_index_q, pal_r_q, pal_g_q, pal_b_q);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        byte_idx_d = 3'd0;
        tx_valid_d = 1'b0;
        ready_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    pixel_req_ready = ready_q;
    // Palette is not offered a handshake while a pixel request competes for it.
    pal_req_ready   = ready_q && !pixel_req_valid;
    tx_data         = tx_data_q;
    tx_valid        = tx_valid_q;
    busy            = (state_q != ST_IDLE);
    req_dropped     = dropped_q;
  end

endmodule

`default_nettype wire
